// File: rtl/dpad_pkg.sv
// Shared constants and types for the d-pad / button conditioning block.
package dpad_pkg;

  // Button channel indices
  localparam int BTN_RIGHT = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;

  // Default timing for a 27 MHz clock
  localparam int         N_BTN_DEF           = 6;
  localparam int         DEBOUNCE_CYCLES_DEF = 270000;    // 10 ms
  localparam int         REPEAT_DELAY_DEF    = 10800000;  // 400 ms
  localparam int         REPEAT_PERIOD_DEF   = 2700000;   // 100 ms
  localparam logic [5:0] REPEAT_MASK_DEF     = 6'b001111; // d-pad repeats, A/B do not

  // Per-channel auto-repeat state
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dpad_btn_chan.sv
// One button channel: 2-flop synchroniser, debounce, press/release pulses
// and the auto-repeat step generator.
module dpad_btn_chan
  import dpad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic repeat_en,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST  = RW'(REPEAT_PERIOD - 1);

  logic          r_sync1, r_sync2;
  logic          w_s;
  logic [DW-1:0] r_dcnt;
  logic          r_pressed, r_press_pulse, r_release_pulse;
  logic          w_differ, w_accept, w_acc_press, w_acc_rel;

  rpt_state_t    r_state, w_state_nx;
  logic [RW-1:0] r_rcnt, w_rcnt_nx;
  logic          r_step, w_step_nx;

  // Synchronise the raw input; reset value 1 means "released"
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s         = ~r_sync2;
  assign w_differ    = (w_s != r_pressed);
  assign w_accept    = w_differ && (r_dcnt == DCNT_LAST);
  assign w_acc_press = w_accept && !r_pressed;
  assign w_acc_rel   = w_accept &&  r_pressed;

  // Debounce: accept a change after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dcnt          <= '0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      if (!w_differ || w_accept) r_dcnt <= '0;
      else                       r_dcnt <= r_dcnt + 1'b1;
      if (w_accept) r_pressed <= ~r_pressed;
      r_press_pulse   <= w_acc_press;
      r_release_pulse <= w_acc_rel;
    end
  end

  // Repeat FSM state, counter and registered step pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_rcnt  <= w_rcnt_nx;
      r_step  <= w_step_nx;
    end
  end

  // Repeat FSM next state; an accepted release overrides any pending expiry
  always_comb begin
    w_state_nx = r_state;
    w_rcnt_nx  = r_rcnt;
    w_step_nx  = 1'b0;
    if (w_acc_rel) begin
      w_state_nx = IDLE;
      w_rcnt_nx  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc_press) begin
            w_step_nx  = 1'b1;
            w_rcnt_nx  = '0;
            w_state_nx = repeat_en ? DELAY : HELD;
          end
        end
        DELAY: begin
          if (r_rcnt == DLY_LAST) begin
            w_step_nx  = 1'b1;
            w_rcnt_nx  = '0;
            w_state_nx = REPEAT;
          end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (r_rcnt == PER_LAST) begin
            w_step_nx = 1'b1;
            w_rcnt_nx = '0;
          end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
          end
        end
        HELD: ;
        default: begin
          w_state_nx = IDLE;
          w_rcnt_nx  = '0;
        end
      endcase
    end
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign step_pulse    = r_step;

endmodule

// File: rtl/dpad_input.sv
// Button conditioning top: one independent channel per button, plus any_pressed.
module dpad_input
  import dpad_pkg::*;
#(
  parameter int               N_BTN           = N_BTN_DEF,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] step_pulse,
  output logic             any_pressed
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    dpad_btn_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .btn_n         (btn_n[i]),
      .repeat_en     (REPEAT_MASK[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .step_pulse    (step_pulse[i])
    );
  end

  // OR of registered levels; no path from btn_n
  assign any_pressed = |pressed;

endmodule
